// File: rtl/brightness_pkg.sv
// Shared defaults, debouncer state encoding and the shift-and-clip helper
// for the brightness gain pipeline.
package brightness_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_GAIN_W     = 4;
  localparam int DEF_FRAC_W     = 3;
  localparam int DEF_GAIN_RESET = 8;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } db_state_t;

  // Returns {clip, value}; value is the product shifted down by frac_w,
  // clamped to all-ones of data_w bits. Upper bits beyond data_w are zero.
  function automatic logic [32:0] sat_shift(input logic [31:0] prod,
                                            input int unsigned data_w,
                                            input int unsigned frac_w);
    logic [31:0] s;
    logic [31:0] max_v;
    s     = prod >> frac_w;
    max_v = (32'd1 << data_w) - 32'd1;
    if (s > max_v) return {1'b1, max_v};
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/key_debounce_edge.sv
// Key synchroniser, debouncer and press-pulse generator for one active-low key.
// Optional auto-repeat is built when BRIGHTNESS_AUTO_REPEAT_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------
// STABLE   | synced key matches the accepted level
// CHANGING | synced key differs; counting toward acceptance
module key_debounce_edge
  import brightness_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int REPEAT_CYC   = 1 << 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);

  logic [1:0]       sync_q;
  logic             synced;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stable, stable_nxt;
  logic             fall;
  logic             press_d;

  assign synced = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      state  <= STABLE;
      cnt    <= '0;
      stable <= 1'b1;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      stable <= stable_nxt;
      press  <= press_d;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stable_nxt = stable;
    fall       = 1'b0;
    case (state)
      STABLE: begin
        if (synced != stable) begin
          state_nxt = CHANGING;
          cnt_nxt   = '0;
        end
      end
      CHANGING: begin
        if (synced == stable) begin
          state_nxt = STABLE;
        end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
          state_nxt  = STABLE;
          stable_nxt = synced;
          fall       = ~synced;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = STABLE;
    endcase
  end

`ifdef BRIGHTNESS_AUTO_REPEAT_EN
  localparam int REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

  logic [REP_W-1:0] rep_cnt;
  logic             rep_fire;

  // Reloaded while released, so the first repeat lands REPEAT_CYC after the press.
  assign rep_fire = ~stable && (rep_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 rep_cnt <= REP_W'(REPEAT_CYC - 1);
    else if (stable || rep_fire) rep_cnt <= REP_W'(REPEAT_CYC - 1);
    else                       rep_cnt <= rep_cnt - 1'b1;
  end

  assign press_d = fall | rep_fire;
`else
  localparam int unused_repeat_cyc = REPEAT_CYC;
  assign press_d = fall;
`endif

endmodule

// File: rtl/brightness_gain_pipe.sv
// Key-controlled fixed-point gain over NUM_CH packed channels, 2-cycle pipeline.
// Build with BRIGHTNESS_AUTO_REPEAT_EN for key auto-repeat.
module brightness_gain_pipe
  import brightness_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int GAIN_W       = DEF_GAIN_W,
  parameter int FRAC_W       = DEF_FRAC_W,
  parameter int GAIN_RESET   = DEF_GAIN_RESET,
  parameter int DEBOUNCE_CYC = 16,
  parameter int REPEAT_CYC   = 1 << 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_up_n,
  input  logic                     key_dn_n,
  input  logic                     frame_start,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_pix,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_pix,
  output logic [GAIN_W-1:0]        gain,
  output logic                     clip
);

  localparam int PROD_W = DATA_W + GAIN_W;

  logic              up_evt, dn_evt;
  logic [GAIN_W-1:0] pend_gain;
  logic              v1;

  wire [NUM_CH*DATA_W-1:0] sat_pix;
  wire [NUM_CH-1:0]        clip_vec;

  key_debounce_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC)) u_key_up (
    .clk   (clk),
    .reset (reset),
    .key_n (key_up_n),
    .press (up_evt)
  );

  key_debounce_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC)) u_key_dn (
    .clk   (clk),
    .reset (reset),
    .key_n (key_dn_n),
    .press (dn_evt)
  );

  // Commit takes the pre-update pending value, so a same-cycle event waits a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_gain <= GAIN_W'(GAIN_RESET);
      gain      <= GAIN_W'(GAIN_RESET);
    end else begin
      if (frame_start) gain <= pend_gain;
      if (up_evt && !dn_evt && (pend_gain != '1))
        pend_gain <= pend_gain + 1'b1;
      else if (dn_evt && !up_evt && (pend_gain != '0))
        pend_gain <= pend_gain - 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PROD_W-1:0] prod_q;
    logic [32:0]       sat_r;
    logic              unused_sat_hi;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)         prod_q <= '0;
      else if (in_valid) prod_q <= PROD_W'(in_pix[c*DATA_W +: DATA_W]) * PROD_W'(gain);
    end

    assign sat_r         = sat_shift(32'(prod_q), DATA_W, FRAC_W);
    assign unused_sat_hi = ^sat_r[31:DATA_W];
    assign sat_pix[c*DATA_W +: DATA_W] = sat_r[DATA_W-1:0];
    assign clip_vec[c]   = sat_r[32];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      clip      <= 1'b0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
      if (v1) begin
        out_pix <= sat_pix;
        clip    <= |clip_vec;
      end
    end
  end

endmodule

// File: tb/tb_brightness_gain_pipe.sv
// Directed key/frame sequence with random pixel bursts checked against a
// arithmetic gain model.
module tb_brightness_gain_pipe;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_up_n, key_dn_n, frame_start, in_valid;
  logic [23:0] in_pix;
  logic        out_valid;
  logic [23:0] out_pix;
  logic [3:0]  gain;
  logic        clip;

  int total = 0;
  int bad   = 0;
  int pend_m, gain_m;
  logic [23:0] last_pix;
  logic        last_clip;

  brightness_gain_pipe #(.DEBOUNCE_CYC(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_up_n    (key_up_n),
    .key_dn_n    (key_dn_n),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .in_pix      (in_pix),
    .out_valid   (out_valid),
    .out_pix     (out_pix),
    .gain        (gain),
    .clip        (clip)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] model(input logic [23:0] p, input int g);
    logic [23:0] o;
    logic        c;
    int          s;
    o = '0;
    c = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      s = (int'(p[ch*8 +: 8]) * g) / 8;
      if (s > 255) begin
        o[ch*8 +: 8] = 8'hFF;
        c = 1'b1;
      end else begin
        o[ch*8 +: 8] = 8'(s);
      end
    end
    return {c, o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input int n, input bit use_dir, input logic [23:0] dir);
    bit          hv[$];
    logic [23:0] hp[$];
    bit          v;
    logic [23:0] p;
    for (int k = 0; k < n + 2; k++) begin
      if (k >= 2) begin
        if (hv[k-2]) {last_clip, last_pix} = model(hp[k-2], gain_m);
        chk("out_valid", 32'(out_valid), 32'(hv[k-2]));
        if (hv[k-2]) chk("clip", 32'(clip), 32'(last_clip));
      end else begin
        chk("out_valid_idle", 32'(out_valid), 32'd0);
      end
      chk("out_pix", 32'(out_pix), 32'(last_pix));
      if (k < n) begin
        v = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        p = (k == 0 && use_dir) ? dir : 24'($urandom);
        hv.push_back(v);
        hp.push_back(p);
        in_valid = v;
        in_pix   = p;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
  endtask

  // fs_cyc > 0 pulses frame_start in that cycle of the hold; D+3 is the press-event cycle.
  task automatic press(input bit up, input bit dn, input int fs_cyc);
    key_up_n = ~up;
    key_dn_n = ~dn;
    for (int c = 1; c <= D + 8; c++) begin
      tick();
      frame_start = (c == fs_cyc);
    end
    frame_start = 1'b0;
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    if (fs_cyc > 0) gain_m = pend_m;
    if (up && !dn)      pend_m = (pend_m == 15) ? 15 : pend_m + 1;
    else if (dn && !up) pend_m = (pend_m == 0) ? 0 : pend_m - 1;
    for (int c = 0; c < D + 8; c++) tick();
  endtask

  task automatic commit();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    gain_m = pend_m;
    tick();
    chk("gain_commit", 32'(gain), 32'(gain_m));
  endtask

  initial begin
    reset = 1'b1;
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    frame_start = 1'b0;
    in_valid = 1'b0;
    in_pix = '0;
    pend_m = 8;
    gain_m = 8;
    last_pix = '0;
    last_clip = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pix", 32'(out_pix), 32'd0);
    chk("rst_clip", 32'(clip), 32'd0);
    chk("rst_gain", 32'(gain), 32'd8);

    // unity gain
    run_burst(6, 1'b1, {8'd50, 8'd100, 8'd200});

    // single up press -> 9
    press(1'b1, 1'b0, 0);
    commit();
    run_burst(6, 1'b1, {8'd0, 8'd0, 8'd200});

    // seven more presses saturate at 15
    repeat (7) press(1'b1, 1'b0, 0);
    commit();
    run_burst(6, 1'b1, {8'd0, 8'd10, 8'd200});

    // down to 14, then a glitch and a simultaneous press must not move it
    press(1'b0, 1'b1, 0);
    key_up_n = 1'b0;
    repeat (D - 2) tick();
    key_up_n = 1'b1;
    repeat (D + 8) tick();
    press(1'b1, 1'b1, 0);
    commit();
    run_burst(8, 1'b0, '0);

    // uncommitted press leaves the active gain alone
    press(1'b1, 1'b0, 0);
    chk("gain_uncommitted", 32'(gain), 32'(gain_m));
    run_burst(8, 1'b0, '0);

    // press landing on frame_start only commits the older pending value
    press(1'b0, 1'b1, D + 3);
    chk("gain_same_cycle", 32'(gain), 32'(gain_m));
    run_burst(6, 1'b0, '0);
    commit();
    run_burst(6, 1'b0, '0);

    // saturate at zero
    repeat (16) press(1'b0, 1'b1, 0);
    commit();
    run_burst(8, 1'b0, '0);

    // asynchronous reset with stage 1 occupied
    in_valid = 1'b1;
    in_pix = 24'($urandom);
    tick();
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_pix", 32'(out_pix), 32'd0);
    chk("midrst_gain", 32'(gain), 32'd8);
    tick();
    reset = 1'b0;
    pend_m = 8;
    gain_m = 8;
    last_pix = '0;
    last_clip = 1'b0;
    tick();
    tick();
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    run_burst(8, 1'b1, {8'd255, 8'd128, 8'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
